// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage with a 2-entry skid buffer.
// in_ready comes straight from a flop, so no ready path crosses the stage.
module pipe_stage_skid #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] xfer_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             main_valid;
    logic             skid_valid;
    logic             rdy_q;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic [CNT_W-1:0] xfer_q;
    logic             accept;
    logic             pop;

    assign accept     = in_valid & rdy_q;
    assign pop        = main_valid & out_ready;

    assign in_ready   = rdy_q;
    assign out_valid  = main_valid;
    assign out_data   = main_data;
    assign occupancy  = state;
    assign xfer_count = xfer_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            rdy_q      <= 1'b1;
            main_data  <= '0;
            skid_data  <= '0;
            xfer_q     <= '0;
        end else begin
            // A pop coinciding with flush still counts as retired.
            if (pop)
                xfer_q <= xfer_q + CNT_ONE;

            if (flush) begin
                state      <= EMPTY;
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
                rdy_q      <= 1'b1;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_data  <= in_data;
                            main_valid <= 1'b1;
                            state      <= ONE;
                        end
                    end
                    ONE: begin
                        unique case (1'b1)
                            accept & pop: begin
                                main_data <= in_data;
                            end
                            accept & ~pop: begin
                                skid_data  <= in_data;
                                skid_valid <= 1'b1;
                                rdy_q      <= 1'b0;
                                state      <= FULL;
                            end
                            ~accept & pop: begin
                                main_valid <= 1'b0;
                                state      <= EMPTY;
                            end
                            default: begin
                            end
                        endcase
                    end
                    FULL: begin
                        if (pop) begin
                            main_data  <= skid_data;
                            skid_valid <= 1'b0;
                            rdy_q      <= 1'b1;
                            state      <= ONE;
                        end
                    end
                    default: begin
                        state      <= EMPTY;
                        main_valid <= 1'b0;
                        skid_valid <= 1'b0;
                        rdy_q      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a queue model.
// A second instance with a 4-bit counter exercises wraparound.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] xfer_count;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_data4;
    logic [1:0]  occupancy4;
    logic [3:0]  xfer_count4;

    int tests = 0;
    int fails = 0;

    logic [31:0] q[$];
    int unsigned m_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .xfer_count(xfer_count)
    );

    pipe_stage_skid #(.WIDTH(32), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .occupancy(occupancy4), .xfer_count(xfer_count4)
    );

    // Drive one cycle and advance the queue model by the handshake rules.
    task automatic cyc(input logic iv, input logic [31:0] d,
                       input logic ordy, input logic fl);
        bit acc;
        bit pp;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        acc = iv && (q.size() < 2);
        pp  = ordy && (q.size() > 0);
        @(posedge clk);
        if (pp) m_cnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL reset_flags: ov=%b ir=%b occ=%0d, want 0 1 0",
                     out_valid, in_ready, occupancy);
        end
        tests++;
        if (out_data !== 32'h0 || xfer_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: data=%h cnt=%0d, want 0 0",
                     out_data, xfer_count);
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h10 + 32'(i), 1'b1, 1'b0);
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'h10 + 32'(i)
                || occupancy !== 2'd1) begin
                fails++;
                $display("FAIL stream_%0d: ov=%b data=%h occ=%0d, want 1 %h 1",
                         i, out_valid, out_data, occupancy, 32'h10 + 32'(i));
            end
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        tests++;
        if (xfer_count !== 16'd4 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_count: cnt=%0d ov=%b, want 4 0",
                     xfer_count, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] c0;
        c0 = xfer_count;
        cyc(1'b1, 32'hA0, 1'b0, 1'b0);
        cyc(1'b1, 32'hA1, 1'b0, 1'b0);
        tests++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA0) begin
            fails++;
            $display("FAIL bp_full: occ=%0d ir=%b data=%h, want 2 0 a0",
                     occupancy, in_ready, out_data);
        end
        cyc(1'b1, 32'hA2, 1'b0, 1'b0);
        tests++;
        if (occupancy !== 2'd2 || out_data !== 32'hA0) begin
            fails++;
            $display("FAIL bp_hold: occ=%0d data=%h, want 2 a0",
                     occupancy, out_data);
        end
        cyc(1'b1, 32'hA2, 1'b1, 1'b0);
        tests++;
        if (out_data !== 32'hA1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_drain1: data=%h occ=%0d ir=%b, want a1 1 1",
                     out_data, occupancy, in_ready);
        end
        cyc(1'b1, 32'hA2, 1'b1, 1'b0);
        tests++;
        if (out_data !== 32'hA2 || occupancy !== 2'd1) begin
            fails++;
            $display("FAIL bp_drain2: data=%h occ=%0d, want a2 1",
                     out_data, occupancy);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        tests++;
        if (out_valid !== 1'b0 || xfer_count !== c0 + 16'd3) begin
            fails++;
            $display("FAIL bp_done: ov=%b cnt=%0d, want 0 %0d",
                     out_valid, xfer_count, c0 + 16'd3);
        end
    endtask

    task automatic test_flush_full();
        logic [15:0] c0;
        c0 = xfer_count;
        cyc(1'b1, 32'hB0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB1, 1'b0, 1'b0);
        cyc(1'b1, 32'hB2, 1'b0, 1'b1);
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1
            || xfer_count !== c0) begin
            fails++;
            $display("FAIL flush_full: ov=%b occ=%0d ir=%b cnt=%0d, want 0 0 1 %0d",
                     out_valid, occupancy, in_ready, xfer_count, c0);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        tests++;
        if (out_valid !== 1'b0 || xfer_count !== c0) begin
            fails++;
            $display("FAIL flush_drop: ov=%b data=%h cnt=%0d, want 0 %0d",
                     out_valid, out_data, xfer_count, c0);
        end
    endtask

    task automatic test_flush_pop();
        logic [15:0] c0;
        c0 = xfer_count;
        cyc(1'b1, 32'hC0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        tests++;
        if (xfer_count !== c0 + 16'd1 || out_valid !== 1'b0
            || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL flush_pop: cnt=%0d ov=%b occ=%0d, want %0d 0 0",
                     xfer_count, out_valid, occupancy, c0 + 16'd1);
        end
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 32'hD0, 1'b0, 1'b0);
        cyc(1'b1, 32'hD1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0
            || xfer_count !== 16'd0) begin
            fails++;
            $display("FAIL async_rst: ov=%b ir=%b occ=%0d cnt=%0d, want 0 1 0 0",
                     out_valid, in_ready, occupancy, xfer_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_wrap();
        bit saw15;
        bit saw0;
        for (int i = 0; i < 18; i++) begin
            cyc(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
            tests++;
            if (xfer_count4 !== 4'(m_cnt)) begin
                fails++;
                $display("FAIL wrap_%0d: cnt=%0d, want %0d",
                         i, xfer_count4, 4'(m_cnt));
            end
            if (xfer_count4 === 4'd15) saw15 = 1'b1;
            if (saw15 && xfer_count4 === 4'd0) saw0 = 1'b1;
        end
        tests++;
        if (!(saw15 && saw0) || xfer_count4 !== 4'd1) begin
            fails++;
            $display("FAIL wrap_end: cnt=%0d saw15=%b saw0=%b, want 1 1 1",
                     xfer_count4, saw15, saw0);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic        iv;
        logic        ordy;
        logic        fl;
        int          bad;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            d    = $urandom;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 63) == 0);
            cyc(iv, d, ordy, fl);
            tests++;
            if (out_valid !== (q.size() > 0)
                || occupancy !== 2'(q.size())
                || in_ready !== (q.size() < 2)
                || xfer_count !== 16'(m_cnt)
                || (q.size() > 0 && out_data !== q[0])) begin
                fails++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_%0d: ov=%b occ=%0d ir=%b cnt=%0d data=%h, want occ=%0d cnt=%0d head=%h",
                             i, out_valid, occupancy, in_ready, xfer_count,
                             out_data, q.size(), 16'(m_cnt),
                             (q.size() > 0) ? q[0] : 32'h0);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_pop();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
